// File: rtl/mem_req_arbiter.sv
// mem_req_arbiter: buffers one miss per cache and grants memory one at a time (D$ first, non-preemptive).
// Ports: clk_i/rst_n (async active-low); dcache_/icache_req_valid_miss + _req_info_miss capture a miss;
// req_mm_valid/req_mm_info/req_mm_ready request memory; rsp_mm_valid/rsp_mm_data return the line;
// rsp_valid_miss/rsp_data_miss/rsp_cache_id (0 = I$, 1 = D$) answer the core; proto_err is sticky.
// Request info layout: {addr[ADDR_W-1:0], is_store, data[`DCACHE_LINE_WIDTH-1:0]}.
// ARB_FAIRNESS_EN: after STARVE_LIMIT consecutive D$ grants over a waiting I$ miss, I$ wins once.
`ifndef DCACHE_LINE_WIDTH
`define DCACHE_LINE_WIDTH 128
`endif

module mem_req_arbiter #(
    parameter int ADDR_W = 32,
`ifdef ARB_FAIRNESS_EN
    parameter int STARVE_LIMIT = 4,
`endif
    localparam int LINE_W = `DCACHE_LINE_WIDTH,
    localparam int REQ_W = ADDR_W + 1 + LINE_W
) (
    input  logic              clk_i,
    input  logic              rst_n,
    input  logic              dcache_req_valid_miss,
    input  logic [REQ_W-1:0]  dcache_req_info_miss,
    input  logic              icache_req_valid_miss,
    input  logic [REQ_W-1:0]  icache_req_info_miss,
    output logic              req_mm_valid,
    output logic [REQ_W-1:0]  req_mm_info,
    input  logic              req_mm_ready,
    input  logic              rsp_mm_valid,
    input  logic [LINE_W-1:0] rsp_mm_data,
    output logic              rsp_valid_miss,
    output logic [LINE_W-1:0] rsp_data_miss,
    output logic              rsp_cache_id,
    output logic              proto_err
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RSP, RESP} state_t;

    state_t             state_q, state_d;
    logic               d_pend_q, i_pend_q, gnt_id_q;
    logic [REQ_W-1:0]   d_buf_q, i_buf_q;
    logic               d_rel, i_rel, d_acc, i_acc;
    logic               grant_d, grant_i, starved, drop, stray_rsp;

    // a source's buffer frees in RESP, so a new miss in that same cycle is legal
    assign d_rel     = state_q == RESP && gnt_id_q;
    assign i_rel     = state_q == RESP && !gnt_id_q;
    assign d_acc     = dcache_req_valid_miss && (!d_pend_q || d_rel);
    assign i_acc     = icache_req_valid_miss && (!i_pend_q || i_rel);
    assign drop      = (dcache_req_valid_miss && !d_acc) || (icache_req_valid_miss && !i_acc);
    assign stray_rsp = rsp_mm_valid && state_q != WAIT_RSP;
    assign grant_d   = state_q == IDLE && d_pend_q && !(i_pend_q && starved);
    assign grant_i   = state_q == IDLE && i_pend_q && !grant_d;
    assign rsp_cache_id = gnt_id_q;

`ifdef ARB_FAIRNESS_EN
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    logic [CNT_W-1:0] starve_q;

    assign starved = starve_q == CNT_W'(STARVE_LIMIT);

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n)
            starve_q <= '0;
        else if (grant_i)
            starve_q <= '0;
        else if (grant_d && i_pend_q)
            starve_q <= starve_q + 1'b1;
    end
`else
    assign starved = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d        = state_q;
        req_mm_valid   = state_q == ISSUE;
        rsp_valid_miss = state_q == RESP;
        case (state_q)
            IDLE:     state_d = (d_pend_q || i_pend_q) ? ISSUE : IDLE;
            ISSUE:    state_d = req_mm_ready ? WAIT_RSP : ISSUE;
            WAIT_RSP: state_d = rsp_mm_valid ? RESP : WAIT_RSP;
            default:  state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            d_pend_q      <= 1'b0;
            i_pend_q      <= 1'b0;
            d_buf_q       <= '0;
            i_buf_q       <= '0;
            gnt_id_q      <= 1'b0;
            req_mm_info   <= '0;
            rsp_data_miss <= '0;
            proto_err     <= 1'b0;
        end else begin
            d_pend_q <= d_acc || (d_pend_q && !d_rel);
            i_pend_q <= i_acc || (i_pend_q && !i_rel);
            if (d_acc)
                d_buf_q <= dcache_req_info_miss;
            if (i_acc)
                i_buf_q <= icache_req_info_miss;
            if (grant_d || grant_i) begin
                gnt_id_q    <= grant_d;
                req_mm_info <= grant_d ? d_buf_q : i_buf_q;
            end
            if (state_q == WAIT_RSP && rsp_mm_valid)
                rsp_data_miss <= rsp_mm_data;
            if (drop || stray_rsp)
                proto_err <= 1'b1;
        end
    end
endmodule

// File: doc/mem_req_arbiter.md
Name: mem_req_arbiter

Overview:
- Synthesizable arbiter between the core's I$/D$ miss ports and the main memory interface.
- Buffers one outstanding miss per cache and grants one at a time to memory; D$ has priority, grants are non-preemptive.
- Routes the memory response back with rsp_cache_id.
- Replaces the behavioural arbitration in the core-level bench; sits directly downstream of core_top and upstream of main memory.

Parameters:
- STARVE_LIMIT, 4: consecutive D$ grants allowed while I$ is pending; used only with the optional feature.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- dcache_req_valid_miss  in  1  D$ miss request pulse.
- dcache_req_info_miss  in  memory_request_t  D$ request (addr, is_store, data).
- icache_req_valid_miss  in  1  I$ miss request pulse.
- icache_req_info_miss  in  memory_request_t  I$ request.
- req_mm_valid  out  1  request to memory.
- req_mm_info  out  memory_request_t  request payload.
- req_mm_ready  in  1  memory accepts request.
- rsp_mm_valid  in  1  memory response (load data or store ack).
- rsp_mm_data  in  `DCACHE_LINE_WIDTH  response line.
- rsp_valid_miss  out  1  response to core, 1-cycle pulse.
- rsp_data_miss  out  `DCACHE_LINE_WIDTH  response line to core.
- rsp_cache_id  out  1  0 = I$, 1 = D$.
- proto_err  out  1  sticky protocol-error flag.

Behaviour:
- Reset (reset low, asynchronous): state IDLE; both pending buffers empty; req_mm_valid=0; req_mm_info='0; rsp_valid_miss=0; rsp_data_miss='0; rsp_cache_id=0; proto_err=0; starve counter 0.
- Capture: valid_miss high latches info into that source's buffer at the clock edge; the buffer is marked pending. Pending is visible to arbitration the following cycle.
- Request while the same source is already pending: request dropped; buffer unchanged; proto_err set until reset.
  - Exception: a request arriving in the same cycle that source's response is delivered (rsp_valid_miss high with its id) is accepted.
- FSM states: IDLE, ISSUE, WAIT_RSP, RESP.
- IDLE:
  - If D$ pending, grant D$.
  - Else if I$ pending, grant I$.
  - On grant: latch grant id, drive req_mm_info from that buffer, go to ISSUE.
- ISSUE:
  - req_mm_valid=1; req_mm_info held stable.
  - On req_mm_ready, go to WAIT_RSP with req_mm_valid=0 next cycle.
  - Handshake completes in the cycle valid&ready are both high.
- WAIT_RSP:
  - On rsp_mm_valid, register rsp_mm_data and go to RESP.
  - No timeout; a D$ request arriving here waits (non-preemptive).
- RESP:
  - rsp_valid_miss=1 for exactly one cycle; rsp_cache_id = grant id; rsp_data_miss = registered data (stores return memory's ack data unchanged).
  - Granted buffer cleared; return to IDLE.
  - rsp_data_miss holds its value afterwards; rsp_valid_miss=0.
- rsp_mm_valid outside WAIT_RSP: ignored; proto_err set.
- Minimum latency, request pulse to rsp_valid_miss with ready=1 and rsp_mm_valid one cycle after handshake: 5 cycles (capture, IDLE grant, ISSUE, WAIT_RSP, RESP).
- Back-to-back: from RESP, IDLE re-arbitrates the next cycle. No combinational path from rsp_mm_valid to rsp_valid_miss.
- Reset asserted mid-transaction: all state discarded immediately; outputs return to reset values; no response is generated for the aborted request.

Optional Feature:
- Macro ARB_FAIRNESS_EN.
- Defined:
  - A counter increments on each D$ grant made while I$ is pending, and clears on any I$ grant.
  - When the count equals STARVE_LIMIT and both sources are pending, IDLE grants I$.
  - Because caches are blocking, this only matters for successive D$ misses while an I$ miss is held.
- Undefined: strict D$ priority; the counter is not instantiated.

Test Plan:
- Single D$ load addr=0x40, ready=1, memory responds 1 cycle after handshake with data 0xA5..A5 -> rsp_valid_miss=1 at cycle 5, rsp_cache_id=1, rsp_data_miss=0xA5..A5, single pulse.
- I$ and D$ pulses in the same cycle (addr 0x400 / 0x80) -> D$ issued first with req_mm_info.addr=0x80; then I$ with addr=0x400; responses delivered in order with ids 1 then 0.
- I$ granted and in WAIT_RSP, then D$ request arrives -> I$ completes first (id 0); D$ is issued in the IDLE cycle following RESP.
- req_mm_ready held low for 10 cycles in ISSUE -> req_mm_valid stays 1 with stable info for 10 cycles; completes normally after ready=1.
- Second D$ pulse while D$ pending -> proto_err=1 and stays 1; original request completes with original addr. Then reset low mid-WAIT_RSP -> all outputs 0 and no rsp_valid_miss.
- With ARB_FAIRNESS_EN and STARVE_LIMIT=2: I$ held pending, D$ re-requests immediately after each response -> grant order D$, D$, I$.
